mmm_operand_shifter: RTL and testbench
======================================

# mmm_operand_shifter

Parametrised operand serialiser for the Montgomery modular multiplier (MMM) datapath of the RSA core. It loads a WIDTH-bit operand and presents it one DIGIT-bit digit per enabled cycle, either LSB-first or MSB-first. It tracks digit count and raises last/done status, so the MMM controller no longer needs an external bit counter. It generalises the fixed 10-bit, 1-bit-per-step operand shifter to any width, radix-2^DIGIT stepping and either scan direction.

## Interface
- WIDTH, 10, operand width in bits (≥ 2)
- DIGIT, 1, bits emitted per step (1 ≤ DIGIT ≤ WIDTH)
- MSB_FIRST, 0, 0 = least-significant digit first, 1 = most-significant digit first
- clk  in  1  clock, rising edge
- rstb  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; gates load and shift
- clr  in  1  synchronous soft clear, per-multiplication restart from the MMM controller
- ld  in  1  load request, sampled when en=1
- din  in  WIDTH  operand to load
- digit_o  out  DIGIT  current digit
- last_o  out  1  digit_o is the final digit of the operand
- busy_o  out  1  operand loaded and not fully consumed
- done_o  out  1  one-cycle pulse after the final digit is consumed

## Operation
- NDIG = ceil(WIDTH/DIGIT). The internal register is NDIG*DIGIT bits, and din is zero-extended at the MSB end.
- States:
  - IDLE: reset state.
  - RUN: digits pending.
  - DONE: one cycle, done_o=1.
- IDLE: when en=1 and ld=1, load the register and set cnt=NDIG, then go to RUN. With en=1 and ld=0 the register holds and there is no shift.
- RUN, en=1, ld=0:
  - MSB_FIRST=0: shift right by DIGIT.
  - MSB_FIRST=1: shift left by DIGIT.
  - Zeros fill the vacated digit. cnt decrements.
  - When cnt==1 at the edge, go to DONE.
- RUN, en=0: register, cnt and state all hold.
- RUN, en=1, ld=1: restart. Reload din, set cnt=NDIG, stay in RUN.
- DONE: go to IDLE on the next edge regardless of en. If en=1 and ld=1 in DONE, load and go to RUN instead.
- digit_o is combinational from the register:
  - MSB_FIRST=0: reg[DIGIT-1:0].
  - MSB_FIRST=1: reg[NDIG*DIGIT-1 -: DIGIT].
- busy_o = (state==RUN). last_o = busy_o & (cnt==1).
- Priority: rstb > clr > ld > shift.
  - clr=1 forces register=0, cnt=0 and IDLE, independent of en.
  - A load is only taken with en=1.
- Outside RUN, digit_o shows the register contents. After completion the register is all zeros, because every digit has been shifted out.
- Reset values: register 0, cnt 0, state IDLE. digit_o=0, last_o=0, busy_o=0, done_o=0.
- cnt width is $clog2(NDIG+1). cnt never underflows: it is only decremented in RUN, and RUN is left when cnt reaches 1.

## Timing
- Load at edge k: digit 0 is valid on digit_o and busy_o=1 from cycle k+1.
- Each enabled edge in RUN consumes the digit currently on digit_o. The next digit appears after that edge.
- With en held high, the operand takes NDIG cycles from first digit to last digit. done_o is high in the cycle after the edge that consumed the last digit, i.e. NDIG+1 cycles after the load edge.
- last_o is high for exactly the cycle(s) in which the final digit is presented; it stays high across en stalls.
- rstb deassertion has no effect until the first rising clk edge; the external reset synchroniser handles release.
- A clr or ld arriving mid-operation takes effect at that edge. No done_o pulse is generated for the aborted operand.

## Structure
- Shared package mmm_pkg holds:
  - the state typedef (IDLE/RUN/DONE, 2 bits);
  - a ceil_div function used for NDIG;
  - the DIGIT/WIDTH legality checks as elaboration-time assertions.
- One sub-module is natural: mmm_digit_counter. It is a loadable down-counter with enable, sync clear and an eq1 flag, parametrised by NDIG. It is reused by the exponent scanner.
- Shifter register, direction mux and FSM stay in the top module.

## Test plan
- WIDTH=10, DIGIT=1, MSB_FIRST=0, en=1, load din=0x2B5:
  - digit_o sequence 1,0,1,0,1,1,0,1,0,1 over 10 cycles;
  - last_o only on the 10th digit;
  - done_o pulse on cycle 11;
  - busy_o=0 afterwards.
- WIDTH=10, DIGIT=4, load 0x2B5:
  - MSB_FIRST=0: digits 0x5, 0xB, 0x2;
  - MSB_FIRST=1: digits 0x2, 0xB, 0x5;
  - NDIG=3 in both cases, with done_o 4 cycles after load.
- en stalls: DIGIT=1, load 0x3FF, then toggle en 1,0,0,1,…
  - digit_o and cnt hold during en=0;
  - done_o appears only after 10 enabled shifts.
- Mid-operation events:
  - After 4 shifts of 0x2B5, assert ld with din=0x001: sequence restarts at 1,0,0,…, and there is no done_o for the first operand.
  - Separately, assert clr together with ld: IDLE, all outputs 0, load ignored.
- Reset: assert rstb=0 asynchronously mid-RUN, between clock edges. All outputs go to 0 immediately; after release, state is IDLE and en without ld produces no shift.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery modular multiplier datapath.
// Holds the operand shifter FSM state type, the digit-count helper and
// the WIDTH/DIGIT legality predicate used at elaboration.
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT-sized slices needed to cover WIDTH bits.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // WIDTH >= 2 and 1 <= DIGIT <= WIDTH.
  function automatic bit params_legal(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width);
  endfunction

endpackage

// File: rtl/mmm_digit_counter.sv
// Loadable down-counter of remaining digits (shared with the exponent scanner).
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear to 0 (highest priority)
//   ld_i   : load NDIG
//   dec_i  : decrement by one
//   cnt_o  : current count
//   eq1_o  : count equals one (final digit pending)
module mmm_digit_counter
  import mmm_pkg::*;
#(
  parameter int unsigned NDIG = 10,
  localparam int unsigned CW  = $clog2(NDIG + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          eq1_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear > load > decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = CW'(NDIG);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign eq1_o = (cnt_q == CW'(1));

endmodule

// File: rtl/mmm_operand_shifter.sv
// Operand serialiser for the MMM datapath: loads a WIDTH-bit operand and
// presents it DIGIT bits per enabled cycle, LSB-first or MSB-first.
//   clk     : clock, rising edge
//   rstb    : asynchronous active-low reset
//   en      : clock enable for load and shift
//   clr     : synchronous soft clear (ignores en)
//   ld      : load request (taken only with en=1)
//   din     : operand to load
//   digit_o : digit currently presented (decoded from the shift register)
//   last_o  : digit_o is the final digit of the operand
//   busy_o  : operand loaded and not fully consumed
//   done_o  : one-cycle pulse after the final digit is consumed
module mmm_operand_shifter
  import mmm_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned DIGIT     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [DIGIT-1:0] digit_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned NDIG = ceil_div(WIDTH, DIGIT);
  localparam int unsigned RW   = NDIG * DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
    $error("mmm_operand_shifter: illegal WIDTH/DIGIT combination");
  end

  state_e        state_q, state_d;
  logic [RW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt;
  logic          cnt_eq1;
  logic          load_c;
  logic          shift_c;

  assign load_c  = en & ld;
  assign shift_c = en & ~ld & (state_q == RUN);

  mmm_digit_counter #(
    .NDIG (NDIG)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rstb),
    .clr_i  (clr),
    .ld_i   (load_c),
    .dec_i  (shift_c),
    .cnt_o  (cnt),
    .eq1_o  (cnt_eq1)
  );

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a load in any state (re)starts the operand.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (load_c) state_d = RUN;
        RUN: begin
          if (load_c) begin
            state_d = RUN;
          end else if (shift_c && cnt_eq1) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = load_c ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register: zero-extended load, zero fill behind the consumed digit.
  always_comb begin
    sh_d = sh_q;
    if (clr) begin
      sh_d = '0;
    end else if (load_c) begin
      sh_d = RW'(din);
    end else if (shift_c) begin
      if (MSB_FIRST) begin
        sh_d = sh_q << DIGIT;
      end else begin
        sh_d = sh_q >> DIGIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  // Outputs decoded from state, count and the register head.
  always_comb begin
    busy_o = (state_q == RUN);
    last_o = (state_q == RUN) && (cnt == CW'(1));
    done_o = (state_q == DONE);
    if (MSB_FIRST) begin
      digit_o = sh_q[RW-1 -: DIGIT];
    end else begin
      digit_o = sh_q[DIGIT-1:0];
    end
  end

endmodule

// File: tb/tb_mmm_operand_shifter.sv
// Scoreboard bench for mmm_operand_shifter: three instances
// (DIGIT=1 LSB-first, DIGIT=4 LSB-first, DIGIT=4 MSB-first).
module tb_mmm_operand_shifter;

  typedef struct {
    bit         is_done;
    logic [3:0] dig;
    bit         last;
    int         cyc;     // expected negedge index, -1 = any
  } ev_t;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [2:0] en_v  = '0;
  logic [2:0] ld_v  = '0;
  logic [2:0] clr_v = '0;
  logic [9:0] din_v [3];
  logic [0:0] dg0;
  logic [3:0] dg1, dg2;
  logic [2:0] lst, bsy, dn;
  logic [3:0] dig [3];

  ev_t exp_q [3][$];
  int  ncyc   = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  assign dig[0] = {3'b000, dg0};
  assign dig[1] = dg1;
  assign dig[2] = dg2;

  mmm_operand_shifter #(.WIDTH(10), .DIGIT(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rstb(rstb), .en(en_v[0]), .clr(clr_v[0]), .ld(ld_v[0]), .din(din_v[0]),
    .digit_o(dg0), .last_o(lst[0]), .busy_o(bsy[0]), .done_o(dn[0]));
  mmm_operand_shifter #(.WIDTH(10), .DIGIT(4), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rstb(rstb), .en(en_v[1]), .clr(clr_v[1]), .ld(ld_v[1]), .din(din_v[1]),
    .digit_o(dg1), .last_o(lst[1]), .busy_o(bsy[1]), .done_o(dn[1]));
  mmm_operand_shifter #(.WIDTH(10), .DIGIT(4), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rstb(rstb), .en(en_v[2]), .clr(clr_v[2]), .ld(ld_v[2]), .din(din_v[2]),
    .digit_o(dg2), .last_o(lst[2]), .busy_o(bsy[2]), .done_o(dn[2]));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare one observed event against the head of the instance's queue.
  task automatic take(input int i, input bit is_done, input logic [3:0] d, input bit l,
                      input bit pop);
    ev_t e;
    checks++;
    if (exp_q[i].size() == 0) begin
      errors++;
      $display("FAIL mon%0d: actual done=%0b digit=%h last=%0b at cyc %0d, required no event",
               i, is_done, d, l, ncyc);
      return;
    end
    e = exp_q[i][0];
    if ((e.is_done != is_done) ||
        (!is_done && ((e.dig != d) || (e.last != l))) ||
        (pop && (e.cyc >= 0) && (e.cyc != ncyc))) begin
      errors++;
      $display("FAIL mon%0d: actual done=%0b digit=%h last=%0b cyc=%0d, required done=%0b digit=%h last=%0b cyc=%0d",
               i, is_done, d, l, ncyc, e.is_done, e.dig, e.last, e.cyc);
    end
    if (pop) void'(exp_q[i].pop_front());
  endtask

  task automatic mon(input int i);
    if (!rstb) return;
    if (dn[i]) take(i, 1'b1, 4'h0, 1'b0, 1'b1);
    if (bsy[i] && en_v[i] && !ld_v[i] && !clr_v[i]) begin
      take(i, 1'b0, dig[i], lst[i], 1'b1);
    end else if (bsy[i] && !en_v[i] && !clr_v[i]) begin
      take(i, 1'b0, dig[i], lst[i], 1'b0);
    end
  endtask

  // Monitor: every negedge, observe all three instances.
  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic push_dig(input int i, input logic [3:0] d, input bit l, input int c);
    ev_t e;
    e.is_done = 1'b0; e.dig = d; e.last = l; e.cyc = c;
    exp_q[i].push_back(e);
  endtask

  task automatic push_done(input int i, input int c);
    ev_t e;
    e.is_done = 1'b1; e.dig = 4'h0; e.last = 1'b0; e.cyc = c;
    exp_q[i].push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [9:0] v);
    en_v[i] = 1'b1; ld_v[i] = 1'b1; din_v[i] = v;
    tick(1);
    ld_v[i] = 1'b0;
  endtask

  task automatic wait_empty(input int i, input string name);
    for (int k = 0; k < 60 && exp_q[i].size() != 0; k++) @(negedge clk);
    #1;
    chk(name, exp_q[i].size(), 0);
  endtask

  task automatic chk_idle(input int i, input string name);
    chk({name, ".busy"}, int'(bsy[i]), 0);
    chk({name, ".last"}, int'(lst[i]), 0);
    chk({name, ".done"}, int'(dn[i]), 0);
    chk({name, ".digit"}, int'(dig[i]), 0);
  endtask

  initial begin
    int base;
    int shifts;
    int t1 [10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    int t2 [3]  = '{5, 11, 2};
    int t3 [3]  = '{2, 11, 5};
    for (int i = 0; i < 3; i++) din_v[i] = '0;

    // Reset state
    tick(2);
    for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("reset%0d", i));
    rstb = 1'b1;
    tick(1);

    // DIGIT=1 LSB-first, 0x2B5, en held high
    load(0, 10'h2B5);
    base = ncyc;
    for (int k = 0; k < 10; k++) push_dig(0, 4'(t1[k]), k == 9, base + 1 + k);
    push_done(0, base + 11);
    tick(11);
    chk_idle(0, "t1_after");
    wait_empty(0, "t1_drain");

    // DIGIT=4 both directions, 0x2B5
    load(1, 10'h2B5);
    base = ncyc;
    for (int k = 0; k < 3; k++) push_dig(1, 4'(t2[k]), k == 2, base + 1 + k);
    push_done(1, base + 4);
    load(2, 10'h2B5);
    base = ncyc;
    for (int k = 0; k < 3; k++) push_dig(2, 4'(t3[k]), k == 2, base + 1 + k);
    push_done(2, base + 4);
    tick(4);
    chk_idle(1, "t2_after");
    chk_idle(2, "t3_after");
    wait_empty(1, "t2_drain");
    wait_empty(2, "t3_drain");

    // en=0 with ld=1 in IDLE: no load
    en_v[1] = 1'b0; ld_v[1] = 1'b1; din_v[1] = 10'h2B5;
    tick(2);
    chk("idle_ld_no_en.busy", int'(bsy[1]), 0);
    ld_v[1] = 1'b0;

    // en stalls on DIGIT=1, 0x3FF, pattern 1,0,0,...
    load(0, 10'h3FF);
    for (int k = 0; k < 10; k++) push_dig(0, 4'h1, k == 9, -1);
    push_done(0, -1);
    shifts = 0;
    for (int k = 0; k < 100 && shifts < 10; k++) begin
      en_v[0] = (k % 3 == 0);
      if (en_v[0]) shifts++;
      tick(1);
    end
    chk("stall.done_after_10", int'(dn[0]), 1);
    en_v[0] = 1'b1;
    tick(2);
    chk("stall.busy_end", int'(bsy[0]), 0);
    wait_empty(0, "stall_drain");

    // Restart mid-operation after 4 shifts with din=0x001
    load(0, 10'h2B5);
    base = ncyc;
    for (int k = 0; k < 4; k++) push_dig(0, 4'(t1[k]), 1'b0, base + 1 + k);
    tick(4);
    ld_v[0] = 1'b1; din_v[0] = 10'h001;
    tick(1);
    ld_v[0] = 1'b0;
    base = ncyc;
    for (int k = 0; k < 10; k++) push_dig(0, (k == 0) ? 4'h1 : 4'h0, k == 9, base + 1 + k);
    push_done(0, base + 11);
    tick(11);
    chk("restart.busy_end", int'(bsy[0]), 0);
    wait_empty(0, "restart_drain");

    // clr together with ld mid-operation
    load(0, 10'h2B5);
    base = ncyc;
    push_dig(0, 4'h1, 1'b0, base + 1);
    push_dig(0, 4'h0, 1'b0, base + 2);
    tick(2);
    clr_v[0] = 1'b1; ld_v[0] = 1'b1; din_v[0] = 10'h3FF;
    tick(1);
    clr_v[0] = 1'b0; ld_v[0] = 1'b0;
    chk_idle(0, "clr_ld");
    tick(3);
    chk("clr_ld.no_load", int'(bsy[0]), 0);
    wait_empty(0, "clr_drain");

    // Asynchronous reset mid-RUN, between edges
    load(1, 10'h2B5);
    base = ncyc;
    push_dig(1, 4'h5, 1'b0, base + 1);
    tick(1);
    #2 rstb = 1'b0;
    #1;
    chk_idle(1, "async_rst");
    @(posedge clk);
    #3 rstb = 1'b1;
    tick(3);
    chk("post_rst.busy", int'(bsy[1]), 0);
    chk("post_rst.digit", int'(dig[1]), 0);
    wait_empty(1, "rst_drain");

    tick(2);
    for (int i = 0; i < 3; i++) chk($sformatf("final_queue%0d", i), exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
